// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler
//   Runs one frame of sprite drawing per frame_tick. It takes a snapshot of every
//   entity register, sweeps a clear over the whole framebuffer, and then visits
//   the ship, the asteroids and the shots in that order. Each live entity goes to
//   its sprite drawer. The pixel stream of the active drawer is registered onto
//   the single framebuffer write port.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   frame_tick          1-cycle request to draw a frame
//   ship_reg            ship entity word
//   asteroid_reg        asteroid entity words, slot 0 in LSBs
//   shot_reg            shot entity words, slot 0 in LSBs
//   entity              entity word presented to the drawers
//   start               one-hot drawer start: [2]=ship [1]=asteroid [0]=shot
//   d_x/d_y/d_color     per-drawer pixel stream, indexed like start
//   d_we, d_done        per-drawer write enable and completion pulse
//   x, y, color, plot   framebuffer write port
//   busy                frame in progress
//   frame_done          1-cycle pulse after the last entity
//   overrun             sticky: frame_tick seen while busy
//   timeout_err         sticky: a drawer never signalled done
//
// state  | meaning
// IDLE   | waiting for frame_tick
// CLEAR  | sweeping color 0 over every pixel, one per cycle
// SELECT | scanning snapshot slot k, skipping dead entities
// START  | entity presented, one-cycle drawer start pulse
// WAIT   | forwarding the active drawer's pixels until done or timeout
// FINISH | frame_done pulse, back to IDLE

module frame_draw_scheduler #(
  parameter int ENTITY_SIZE   = 34,
  parameter int MAX_ASTEROIDS = 5,
  parameter int MAX_SHOTS     = 10,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int TIMEOUT       = 4096
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               frame_tick,
  input  logic [ENTITY_SIZE-1:0]             ship_reg,
  input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroid_reg,
  input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]   shot_reg,
  output logic [ENTITY_SIZE-1:0]             entity,
  output logic [2:0]                         start,
  input  logic [29:0]                        d_x,
  input  logic [29:0]                        d_y,
  input  logic [8:0]                         d_color,
  input  logic [2:0]                         d_we,
  input  logic [2:0]                         d_done,
  output logic [9:0]                         x,
  output logic [9:0]                         y,
  output logic [2:0]                         color,
  output logic                               plot,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               overrun,
  output logic                               timeout_err
);

  localparam int NUM_ENT = 1 + MAX_ASTEROIDS + MAX_SHOTS;
  localparam int KW      = $clog2(NUM_ENT);
  localparam int TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [KW-1:0] LAST_K    = KW'(NUM_ENT - 1);
  localparam logic [KW-1:0] LAST_AST  = KW'(MAX_ASTEROIDS);
  localparam logic [9:0]    X_LAST    = 10'(SCREEN_W - 1);
  localparam logic [9:0]    Y_LAST    = 10'(SCREEN_H - 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SELECT,
    S_START,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  // Snapshot slots: 0 = ship, 1..MAX_ASTEROIDS = asteroids, then shots.
  logic [ENTITY_SIZE-1:0] snap_q [NUM_ENT];
  logic                   snap_load;

  logic [KW-1:0]          k_q, k_d;
  logic [9:0]             cx_q, cx_d;
  logic [9:0]             cy_q, cy_d;
  logic [TW-1:0]          wait_q, wait_d;
  logic [1:0]             act_q, act_d;
  logic [ENTITY_SIZE-1:0] entity_q, entity_d;
  logic [2:0]             start_q, start_d;
  logic [9:0]             x_q, x_d;
  logic [9:0]             y_q, y_d;
  logic [2:0]             color_q, color_d;
  logic                   plot_q, plot_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_err_q, timeout_err_d;

  logic [ENTITY_SIZE-1:0] cur_ent;
  logic [1:0]             cur_type;
  logic [9:0]             sel_x;
  logic [9:0]             sel_y;
  logic [2:0]             sel_color;
  logic                   sel_we;
  logic                   sel_done;

  assign cur_ent = snap_q[k_q];

  // Drawer index follows the start bit numbering: 2 = ship, 1 = asteroid, 0 = shot.
  always_comb begin
    cur_type = 2'd0;
    if (k_q == '0) begin
      cur_type = 2'd2;
    end else if (k_q <= LAST_AST) begin
      cur_type = 2'd1;
    end
  end

  always_comb begin
    sel_x     = d_x[9:0];
    sel_y     = d_y[9:0];
    sel_color = d_color[2:0];
    sel_we    = d_we[0];
    sel_done  = d_done[0];
    case (act_q)
      2'd2: begin
        sel_x     = d_x[29:20];
        sel_y     = d_y[29:20];
        sel_color = d_color[8:6];
        sel_we    = d_we[2];
        sel_done  = d_done[2];
      end
      2'd1: begin
        sel_x     = d_x[19:10];
        sel_y     = d_y[19:10];
        sel_color = d_color[5:3];
        sel_we    = d_we[1];
        sel_done  = d_done[1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    snap_load     = 1'b0;
    k_d           = k_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    wait_d        = wait_q;
    act_d         = act_q;
    entity_d      = entity_q;
    start_d       = 3'b000;
    x_d           = x_q;
    y_d           = y_q;
    color_d       = color_q;
    plot_d        = 1'b0;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    // Any tick outside IDLE is dropped; nothing is queued.
    overrun_d     = overrun_q | (frame_tick & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          snap_load = 1'b1;
          busy_d    = 1'b1;
          cx_d      = '0;
          cy_d      = '0;
          k_d       = '0;
          state_d   = S_CLEAR;
        end
      end

      S_CLEAR: begin
        x_d     = cx_q;
        y_d     = cy_q;
        color_d = 3'd0;
        plot_d  = 1'b1;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            cy_d    = '0;
            k_d     = '0;
            state_d = S_SELECT;
          end else begin
            cy_d = cy_q + 10'd1;
          end
        end else begin
          cx_d = cx_q + 10'd1;
        end
      end

      S_SELECT: begin
        if (cur_ent[ENTITY_SIZE-1]) begin
          entity_d = cur_ent;
          act_d    = cur_type;
          start_d  = 3'b001 << cur_type;
          state_d  = S_START;
        end else if (k_q == LAST_K) begin
          frame_done_d = 1'b1;
          state_d      = S_FINISH;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_START: begin
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        x_d     = sel_x;
        y_d     = sel_y;
        color_d = sel_color;
        plot_d  = sel_we;
        // done on the terminal-count cycle still counts as a clean finish
        if (sel_done || (wait_q == '0)) begin
          if (!sel_done) begin
            timeout_err_d = 1'b1;
            plot_d        = 1'b0;
          end
          if (k_q == LAST_K) begin
            frame_done_d = 1'b1;
            state_d      = S_FINISH;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_SELECT;
          end
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        snap_q[i] <= '0;
      end
    end else if (snap_load) begin
      snap_q[0] <= ship_reg;
      for (int i = 0; i < MAX_ASTEROIDS; i++) begin
        snap_q[1 + i] <= asteroid_reg[i*ENTITY_SIZE +: ENTITY_SIZE];
      end
      for (int i = 0; i < MAX_SHOTS; i++) begin
        snap_q[1 + MAX_ASTEROIDS + i] <= shot_reg[i*ENTITY_SIZE +: ENTITY_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      wait_q        <= '0;
      act_q         <= '0;
      entity_q      <= '0;
      start_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      color_q       <= '0;
      plot_q        <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      wait_q        <= wait_d;
      act_q         <= act_d;
      entity_q      <= entity_d;
      start_q       <= start_d;
      x_q           <= x_d;
      y_q           <= y_d;
      color_q       <= color_d;
      plot_q        <= plot_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign entity      = entity_q;
  assign start       = start_q;
  assign x           = x_q;
  assign y           = y_q;
  assign color       = color_q;
  assign plot        = plot_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
